// File: rtl/jtkicker_intctl.sv
`default_nettype none
// ============================================================================
// jtkicker_intctl : addressable latch, edge-captured interrupts, line routing
//                   and vblank watchdog for Konami-style 6809 main boards
// Revision 1.0
// ============================================================================
module jtkicker_intctl #(
  parameter int          CH          = 1,
  parameter logic [23:0] EN_BIT      = 24'o7,
  parameter logic [7:0]  LINE        = 8'h00,
  parameter logic [3:0]  POL         = 4'h0,
  parameter logic [15:0] PRESC       = 16'h0,
  parameter int          WDOG_FRAMES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_cen,
  input  logic          LVBL,
  input  logic          dip_pause,
  input  logic [CH-1:0] src,
  input  logic          latch_we,
  input  logic [2:0]    latch_addr,
  input  logic          latch_din,
  input  logic          kick,
  output logic [7:0]    latch_q,
  output logic          irq_n,
  output logic          firq_n,
  output logic          nmi_n,
  output logic [CH-1:0] pending,
  output logic          wdog_rst
);

  logic [7:0]    latch_d;
  logic [CH-1:0] src_q;
  logic [CH-1:0] pend_vec;
  logic          irq_any, firq_any, nmi_any;

  always_comb begin
    latch_d = latch_q;
    if (cpu_cen && latch_we) latch_d[latch_addr] = latch_din;
  end

  // src_q loads src in reset too, so the first sample after reset sees no edge
  always_ff @(posedge clk) begin
    src_q <= src;
    if (rst) latch_q <= 8'd0;
    else     latch_q <= latch_d;
  end

  for (genvar n = 0; n < CH; n++) begin : g_ch
    localparam logic [2:0] c_EN   = EN_BIT[3*n +: 3];
    localparam logic [3:0] c_DIV  = PRESC[4*n +: 4];
    localparam logic [3:0] c_LAST = (c_DIV == 4'd0) ? 4'd0 : c_DIV - 4'd1;

    logic [3:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       en, hit;

    // Needs old and new enable: an enabling write loses the edge, a disabling one clears it
    assign en  = latch_q[c_EN] & latch_d[c_EN];
    assign hit = dip_pause & (POL[n] ? (src[n] & ~src_q[n]) : (~src[n] & src_q[n]));

    always_comb begin
      cnt_d  = cnt_q;
      pend_d = pend_q;
      if (!en) begin
        cnt_d  = 4'd0;
        pend_d = 1'b0;
      end else if (hit) begin
        if (cnt_q == c_LAST) begin
          cnt_d  = 4'd0;
          pend_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + 4'd1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= 4'd0;
        pend_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        pend_q <= pend_d;
      end
    end

    assign pend_vec[n] = pend_q;
  end

  always_comb begin
    irq_any  = 1'b0;
    firq_any = 1'b0;
    nmi_any  = 1'b0;
    for (int n = 0; n < CH; n++) begin
      case (LINE[2*n +: 2])
        2'd0:    irq_any  = irq_any  | pend_vec[n];
        2'd1:    firq_any = firq_any | pend_vec[n];
        2'd2:    nmi_any  = nmi_any  | pend_vec[n];
        default: ;
      endcase
    end
  end

  assign irq_n   = ~irq_any;
  assign firq_n  = ~firq_any;
  assign nmi_n   = ~nmi_any;
  assign pending = pend_vec;

  if (WDOG_FRAMES > 0) begin : g_wdog
    localparam int c_WW = $clog2(WDOG_FRAMES + 1);

    logic [c_WW-1:0] wcnt_q, wcnt_d;
    logic [4:0]      pulse_q, pulse_d;
    logic            lvbl_q;
    logic            kicked, tick, expire;

    assign kicked = cpu_cen & kick;
    assign tick   = lvbl_q & ~LVBL & dip_pause;
    assign expire = tick & ~kicked & (wcnt_q == c_WW'(WDOG_FRAMES - 1));

    always_comb begin
      wcnt_d  = wcnt_q;
      pulse_d = pulse_q;
      if (kicked)      wcnt_d = '0;
      else if (expire) wcnt_d = '0;
      else if (tick)   wcnt_d = wcnt_q + c_WW'(1);
      if (expire)              pulse_d = 5'd16;
      else if (pulse_q != 5'd0) pulse_d = pulse_q - 5'd1;
    end

    always_ff @(posedge clk) begin
      lvbl_q <= LVBL;
      if (rst) begin
        wcnt_q  <= '0;
        pulse_q <= 5'd0;
      end else begin
        wcnt_q  <= wcnt_d;
        pulse_q <= pulse_d;
      end
    end

    assign wdog_rst = |pulse_q;
  end else begin : g_no_wdog
    logic unused_wdog;
    assign unused_wdog = &{1'b0, LVBL, kick};
    assign wdog_rst    = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_jtkicker_intctl.sv
`default_nettype none
// ============================================================================
// tb_jtkicker_intctl : scoreboard bench, 4 channels (IRQ, NMI/4, IRQ, FIRQ),
//                      watchdog at 3 frames
// Revision 1.0
// ============================================================================
module tb_jtkicker_intctl;

  logic       clk = 1'b0;
  logic       rst, cpu_cen, LVBL, dip_pause, latch_we, latch_din, kick;
  logic [3:0] src;
  logic [2:0] latch_addr;
  logic [7:0] latch_q;
  logic       irq_n, firq_n, nmi_n, wdog_rst;
  logic [3:0] pending;

  jtkicker_intctl #(
    .CH(4), .EN_BIT(24'o4567), .LINE(8'h48), .POL(4'b1110),
    .PRESC(16'h0040), .WDOG_FRAMES(3)
  ) u_dut (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .LVBL(LVBL), .dip_pause(dip_pause),
    .src(src), .latch_we(latch_we), .latch_addr(latch_addr), .latch_din(latch_din),
    .kick(kick), .latch_q(latch_q), .irq_n(irq_n), .firq_n(firq_n), .nmi_n(nmi_n),
    .pending(pending), .wdog_rst(wdog_rst)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int wd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of the configured board
  int m_enb[4]   = '{7, 6, 5, 4};
  int m_pol[4]   = '{0, 1, 1, 1};
  int m_div[4]   = '{1, 4, 1, 1};
  int m_line[4]  = '{0, 2, 0, 1};
  logic [7:0] m_latch;
  logic [3:0] m_src, m_pend;
  int         m_cnt[4];
  logic       m_lvbl;
  int         m_wcnt, m_pulse;

  typedef struct {
    logic [7:0] lq;
    logic       irq, firq, nmi;
    logic [3:0] pend;
    logic       wd;
  } exp_t;
  exp_t sb[$];

  task model_step();
    logic [7:0] nl;
    bit         ok, edg, trig;
    if (rst) begin
      m_latch = 8'd0; m_src = src; m_pend = 4'd0; m_lvbl = LVBL;
      m_wcnt = 0; m_pulse = 0;
      for (int c = 0; c < 4; c++) m_cnt[c] = 0;
    end else begin
      nl = m_latch;
      if (cpu_cen && latch_we) nl[latch_addr] = latch_din;
      for (int c = 0; c < 4; c++) begin
        ok  = m_latch[m_enb[c]] && nl[m_enb[c]];
        edg = dip_pause && (m_pol[c] == 1 ? (src[c] && !m_src[c]) : (!src[c] && m_src[c]));
        if (!ok) begin
          m_pend[c] = 1'b0; m_cnt[c] = 0;
        end else if (edg) begin
          m_cnt[c]++;
          if (m_cnt[c] >= m_div[c]) begin m_cnt[c] = 0; m_pend[c] = 1'b1; end
        end
      end
      trig = 1'b0;
      if (cpu_cen && kick) m_wcnt = 0;
      else if (m_lvbl && !LVBL && dip_pause) begin
        m_wcnt++;
        if (m_wcnt == 3) begin m_wcnt = 0; trig = 1'b1; end
      end
      if (trig) m_pulse = 16;
      else if (m_pulse > 0) m_pulse--;
      m_src = src; m_lvbl = LVBL; m_latch = nl;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.lq = m_latch; e.pend = m_pend; e.wd = (m_pulse > 0);
    e.irq = 1'b1; e.firq = 1'b1; e.nmi = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (m_pend[c] && m_line[c] == 0) e.irq  = 1'b0;
      if (m_pend[c] && m_line[c] == 1) e.firq = 1'b0;
      if (m_pend[c] && m_line[c] == 2) e.nmi  = 1'b0;
    end
    return e;
  endfunction

  task cyc();
    exp_t e;
    model_step();
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("sb_latch", 32'(latch_q), 32'(e.lq));
      chk("sb_pend",  32'(pending), 32'(e.pend));
      chk("sb_irq",   32'(irq_n),   32'(e.irq));
      chk("sb_firq",  32'(firq_n),  32'(e.firq));
      chk("sb_nmi",   32'(nmi_n),   32'(e.nmi));
      chk("sb_wdog",  32'(wdog_rst), 32'(e.wd));
    end
    if (wdog_rst === 1'b1) wd_cnt++;
  endtask

  task wr(input int a, input bit d, input bit cen = 1'b1);
    latch_addr = 3'(a); latch_din = d; latch_we = 1'b1; cpu_cen = cen;
    cyc();
    latch_we = 1'b0; cpu_cen = 1'b0;
  endtask

  task rise1();
    src[1] = 1'b1; cyc();
    src[1] = 1'b0; cyc();
  endtask

  task frame(input bit with_kick);
    LVBL = 1'b0;
    if (with_kick) begin cpu_cen = 1'b1; kick = 1'b1; end
    cyc();
    kick = 1'b0; cpu_cen = 1'b0;
    cyc();
    LVBL = 1'b1; cyc(); cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cpu_cen = 1'b0; LVBL = 1'b1; dip_pause = 1'b1; src = 4'b0001;
    latch_we = 1'b0; latch_addr = 3'd0; latch_din = 1'b0; kick = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("rst_latch", 32'(latch_q), 32'h00);
    chk("rst_lines", {29'd0, irq_n, firq_n, nmi_n}, 32'h7);
    chk("rst_wdog",  32'(wdog_rst), 32'd0);

    // ch0 falling edge -> IRQ, acknowledge by writing the enable low
    wr(7, 1'b1);
    src[0] = 1'b0; cyc();
    chk("irq_set", 32'(irq_n), 32'd0);
    wr(7, 1'b0);
    chk("irq_ack", 32'(irq_n), 32'd1);
    src[0] = 1'b1; cyc();

    // ch1 divides by 4 onto NMI
    wr(6, 1'b1);
    repeat (3) rise1();
    chk("nmi_pre", 32'(nmi_n), 32'd1);
    rise1();
    chk("nmi_set", 32'(nmi_n), 32'd0);
    wr(6, 1'b0);
    chk("nmi_ack", 32'(nmi_n), 32'd1);
    wr(6, 1'b1);
    repeat (3) rise1();
    chk("nmi_pre2", 32'(nmi_n), 32'd1);
    rise1();
    chk("nmi_set2", 32'(nmi_n), 32'd0);
    wr(6, 1'b0);

    // two IRQ channels share the line
    wr(7, 1'b1); wr(5, 1'b1);
    src[0] = 1'b0; cyc();
    src[2] = 1'b1; cyc();
    wr(7, 1'b0);
    chk("irq_hold", 32'(irq_n), 32'd0);
    chk("pend_ch2", 32'(pending), 32'h4);
    wr(5, 1'b0);
    chk("irq_both_ack", 32'(irq_n), 32'd1);
    src[0] = 1'b1; src[2] = 1'b0; cyc();

    // paused edge is dropped
    wr(7, 1'b1);
    dip_pause = 1'b0; src[0] = 1'b0; cyc();
    dip_pause = 1'b1; cyc();
    chk("pause_drop", 32'(pending[0]), 32'd0);
    src[0] = 1'b1; cyc();
    // enable write in the same clk as the edge
    wr(7, 1'b0);
    src[0] = 1'b0; wr(7, 1'b1);
    chk("en_same", 32'(pending[0]), 32'd0);
    src[0] = 1'b1; cyc();
    // disable write in the same clk as the edge
    src[0] = 1'b0; wr(7, 1'b0);
    chk("dis_same", 32'(pending[0]), 32'd0);
    chk("dis_same_irq", 32'(irq_n), 32'd1);
    src[0] = 1'b1; cyc();

    // ch3 rising edge -> FIRQ
    wr(4, 1'b1);
    src[3] = 1'b1; cyc();
    chk("firq_set", 32'(firq_n), 32'd0);
    wr(4, 1'b0);
    chk("firq_ack", 32'(firq_n), 32'd1);
    src[3] = 1'b0; cyc();

    // watchdog expiry pulse width
    wd_cnt = 0;
    repeat (3) frame(1'b0);
    repeat (20) cyc();
    chk("wd_width", 32'(wd_cnt), 32'd16);

    // paused frames do not count; kicks keep it quiet (incl. kick on an LVBL edge)
    wd_cnt = 0;
    dip_pause = 1'b0;
    repeat (3) frame(1'b0);
    dip_pause = 1'b1;
    chk("wd_pause", 32'(wd_cnt), 32'd0);
    frame(1'b0);
    cpu_cen = 1'b1; kick = 1'b1; cyc(); kick = 1'b0; cpu_cen = 1'b0;
    repeat (3) begin frame(1'b0); frame(1'b0); frame(1'b1); end
    repeat (4) cyc();
    chk("wd_kicked", 32'(wd_cnt), 32'd0);

    // reset during the pulse
    repeat (3) frame(1'b0);
    chk("wd_on", 32'(wdog_rst), 32'd1);
    rst = 1'b1; cyc();
    chk("wd_rst_drop", 32'(wdog_rst), 32'd0);
    rst = 1'b0; cyc();

    // latch walk
    for (int a = 0; a < 8; a++) begin
      wr(a, 1'b1);
      chk("latch_set", 32'(latch_q), 32'd1 << a);
      wr(a, 1'b0);
      chk("latch_clr", 32'(latch_q), 32'd0);
    end
    wr(3, 1'b1, 1'b0);
    chk("latch_nocen", 32'(latch_q), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtkicker_intctl.md
# jtkicker_intctl

Parametrised interrupt and watchdog controller for Konami-style 6809 main boards. It merges the addressable output latch (74LS259 equivalent), per-channel interrupt edge capture with frame prescalers, CPU line routing (nIRQ/nFIRQ/nNMI) and a vblank-counting watchdog into one block. It sits between the video timing/address decoder and the CPU wrapper, and replaces the hand-wired single-IRQ flip-flop and fixed latch in each core's main module.

## Interface
Parameters:
- CH, 1: number of interrupt channels (1–4).
- EN_BIT, 24'o7: 3 bits per channel (channel n at [3n+2:3n]); the latch bit that enables and acknowledges the channel.
- LINE, 8'h00: 2 bits per channel. 0 = IRQ, 1 = FIRQ, 2 = NMI, 3 = channel unused.
- POL, 4'h0: 1 bit per channel. 0 = falling edge of src triggers, 1 = rising edge triggers.
- PRESC, 16'h0: 4 bits per channel; number of qualifying edges per interrupt. 0 is treated as 1.
- WDOG_FRAMES, 0: vblank count to watchdog expiry. 0 disables the watchdog.

Ports:
- clk  in  1  system clock (24 MHz).
- rst  in  1  synchronous, active-high reset.
- cpu_cen  in  1  CPU bus clock enable. Latch writes are sampled only on this.
- LVBL  in  1  vertical blank, active low (watchdog time base).
- dip_pause  in  1  low = paused. Blocks new edge captures and freezes the watchdog.
- src  in  CH  interrupt source signals, synchronous to clk.
- latch_we  in  1  CPU write strobe to the latch area (decoded cs & !RnW).
- latch_addr  in  3  latch bit address (A[2:0]).
- latch_din  in  1  data bit (cpu_dout[0]).
- kick  in  1  watchdog clear strobe (afe decode), sampled on cpu_cen.
- latch_q  out  8  latch outputs (flip, sound IRQ, coin counters, enables).
- irq_n  out  1  to CPU nIRQ.
- firq_n  out  1  to CPU nFIRQ.
- nmi_n  out  1  to CPU nNMI.
- pending  out  CH  raw pending flags, for debug.
- wdog_rst  out  1  watchdog reset request, active high.

## Operation
- Latch: on clk with cpu_cen & latch_we, latch_q[latch_addr] <= latch_din. Other bits hold.
- Edge detect per channel: src is registered every clk. A qualifying edge is the POL-selected transition, gated by dip_pause=1.
- Enable: en_n = latch_q[EN_BIT_n].
  - While en_n = 0: pending_n is held 0 and the prescaler is held 0. This is clear-dominant, so a write of 0 is the acknowledge.
- Prescaler: while enabled, each qualifying edge increments cnt_n.
  - When cnt_n reaches max(PRESC_n,1)-1 at an edge: cnt_n wraps to 0 and pending_n is set.
  - Further edges while pending_n = 1 keep counting but do not stack.
- Output routing: each output line is the OR of the pending flags routed to it, inverted. Example: irq_n = ~|(pending & LINE==0).
  - Outputs are combinational from registered pending flags.
  - LINE=3 channels never drive any output.
- Watchdog (WDOG_FRAMES>0): wcnt counts LVBL falling edges while dip_pause=1.
  - kick on cpu_cen clears wcnt.
  - When wcnt reaches WDOG_FRAMES: wdog_rst goes high for 16 clk cycles, and wcnt clears.
  - kick and an LVBL edge in the same clk: kick wins (wcnt=0).
- Reset values: latch_q=0, pending=0, all cnt=0, wcnt=0, wdog_rst=0, so irq_n = firq_n = nmi_n = 1. Edge registers load the current src, so no spurious edge follows reset.

## Timing
- src edge at clk k (src differs from the previous sample): pending set at clk k+1, and the line asserts in the same cycle.
- An enable write and a qualifying edge in the same clk: the edge sees the old enable. If the old enable was 0, the edge is lost.
- A disable write in the same clk as a pending-setting edge: the clear wins. Pending is 0 after the edge.
- latch_q updates one clk after the cpu_cen&latch_we cycle.
- Reset asserted mid-pulse of wdog_rst: wdog_rst drops on the next clk.
- A change to dip_pause takes effect on the next clk. Edges occurring while dip_pause=0 are discarded, not deferred.

## Test plan
- Reset, then write latch bit 7=1 (EN_BIT=7, LINE=0, POL=0), then drop LVBL on src[0] → irq_n=0 one clk after the edge. Write bit 7=0 → irq_n=1 next clk.
- PRESC_1=4, LINE_1=2, enabled: 3 src[1] rising edges → nmi_n stays 1. 4th edge → nmi_n=0. Ack, re-enable, then 4 more edges → nmi_n=0 again.
- Two channels, both LINE=0: ack only channel 0 → irq_n stays 0 until channel 1 is acked.
- dip_pause=0 during an edge → no pending. Same-cycle enable write plus edge → no pending. Same-cycle disable plus edge → pending 0.
- WDOG_FRAMES=3, no kick, 3 LVBL falls → wdog_rst high for exactly 16 clks. A kick every 2 frames → wdog_rst never asserts.
- Write 1 then 0 to each of the 8 latch addresses → only the addressed latch_q bit changes. A write without cpu_cen → no change.
